// File: rtl/ask_demod.sv
// ---------------------------------------------------------------------------
// ask_demod
//
// Non-coherent ASK demodulator. Takes the 8-bit modulated sample stream
// (gated carrier, constant level for a 0 bit) and recovers one data bit per
// bit period. Each bit is decided from the peak-to-peak swing of a
// BIT_LEN-sample integrate-and-dump window.
//
// The first window is aligned to a detected carrier onset, which is a large
// sample-to-sample step seen while searching. Lock is dropped after
// LOSS_CNT consecutive 0 decisions.
//
// Ports
//   clk        in   1  system clock, one sample per cycle
//   rst_n      in   1  asynchronous active-low reset
//   din        in   8  unsigned modulated sample
//   bit_out    out  1  last decided bit, held between decisions
//   bit_valid  out  1  one-cycle strobe, bit_out is new this cycle
//   locked     out  1  high while windows are being decided
//   pp_last    out  8  peak-to-peak value of the last decided window
// ---------------------------------------------------------------------------
module ask_demod #(
    parameter int BIT_LEN  = 256,   // samples per bit, 4..65535
    parameter int PP_TH    = 64,    // min peak-to-peak decided as 1
    parameter int EDGE_TH  = 32,    // min |step| declaring carrier onset
    parameter int LOSS_CNT = 8      // consecutive zeros that drop lock, 1..255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       locked,
    output logic [7:0] pp_last
);

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCK   = 1'b1;

    localparam logic [15:0] LAST_IDX  = 16'(BIT_LEN - 1);
    localparam logic [8:0]  PP_TH_L   = 9'(PP_TH);
    localparam logic [8:0]  EDGE_TH_L = 9'(EDGE_TH);
    localparam logic [7:0]  LOSS_L    = 8'(LOSS_CNT);

    logic [0:0]  state_q,    state_d;
    logic [7:0]  prev_q,     prev_d;
    logic        prev_ok_q,  prev_ok_d;
    logic [7:0]  max_q,      max_d;
    logic [7:0]  min_q,      min_d;
    logic [15:0] cnt_q,      cnt_d;
    logic [7:0]  zero_cnt_q, zero_cnt_d;
    logic        bit_q,      bit_d;
    logic        valid_q,    valid_d;
    logic [7:0]  pp_last_q,  pp_last_d;

    logic [7:0]        mx;
    logic [7:0]        mn;
    logic [7:0]        pp;
    logic [7:0]        zero_inc;
    logic signed [8:0] diff_s;
    logic [8:0]        diff_abs;
    logic              decided_one;

    always_comb begin
        state_d    = state_q;
        prev_d     = din;
        prev_ok_d  = 1'b1;
        max_d      = max_q;
        min_d      = min_q;
        cnt_d      = cnt_q;
        zero_cnt_d = zero_cnt_q;
        bit_d      = bit_q;
        valid_d    = 1'b0;
        pp_last_d  = pp_last_q;

        // Running extremes including the current sample. mx >= mn always
        // holds here because the window is seeded with max=0/min=255 and the
        // current sample is folded into both, so pp never wraps.
        mx          = (din > max_q) ? din : max_q;
        mn          = (din < min_q) ? din : min_q;
        pp          = mx - mn;
        decided_one = ({1'b0, pp} >= PP_TH_L);
        zero_inc    = zero_cnt_q + 8'd1;

        // Sample-to-sample step magnitude, 9-bit to cover the full -255..255.
        diff_s   = $signed({1'b0, din}) - $signed({1'b0, prev_q});
        diff_abs = diff_s[8] ? 9'(-diff_s) : 9'(diff_s);

        case (state_q)
            ST_SEARCH: begin
                if (prev_ok_q && (diff_abs >= EDGE_TH_L)) begin
                    // The onset sample is the first sample of the first window.
                    state_d    = ST_LOCK;
                    max_d      = din;
                    min_d      = din;
                    cnt_d      = 16'd1;
                    zero_cnt_d = 8'd0;
                end
            end
            default: begin
                if (cnt_q != LAST_IDX) begin
                    max_d = mx;
                    min_d = mn;
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    bit_d     = decided_one;
                    valid_d   = 1'b1;
                    pp_last_d = pp;
                    // Neutral seed: the next sample becomes both max and min.
                    max_d     = 8'd0;
                    min_d     = 8'd255;
                    cnt_d     = 16'd0;
                    if (decided_one) begin
                        zero_cnt_d = 8'd0;
                    end else begin
                        zero_cnt_d = zero_inc;
                        // The final zero is still emitted; lock falls on the
                        // same edge so a new onset can be seen next cycle.
                        if (zero_inc == LOSS_L) begin
                            state_d = ST_SEARCH;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SEARCH;
            prev_q     <= 8'd0;
            prev_ok_q  <= 1'b0;
            max_q      <= 8'd0;
            min_q      <= 8'd0;
            cnt_q      <= 16'd0;
            zero_cnt_q <= 8'd0;
            bit_q      <= 1'b0;
            valid_q    <= 1'b0;
            pp_last_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            prev_ok_q  <= prev_ok_d;
            max_q      <= max_d;
            min_q      <= min_d;
            cnt_q      <= cnt_d;
            zero_cnt_q <= zero_cnt_d;
            bit_q      <= bit_d;
            valid_q    <= valid_d;
            pp_last_q  <= pp_last_d;
        end
    end

    assign bit_out   = bit_q;
    assign bit_valid = valid_q;
    assign locked    = (state_q == ST_LOCK);
    assign pp_last   = pp_last_q;

endmodule

// File: tb/tb_ask_demod.sv
// ---------------------------------------------------------------------------
// tb_ask_demod
//
// Self-checking bench for ask_demod with BIT_LEN=16, PP_TH=64, EDGE_TH=32,
// LOSS_CNT=3. A behavioural model keeps the current window as a queue of
// samples and decides each bit from the queue's max minus min. Directed
// scenarios are followed by randomized carrier/constant segments with
// occasional asynchronous resets.
// ---------------------------------------------------------------------------
module tb_ask_demod;

    localparam int BIT_LEN  = 16;
    localparam int PP_TH    = 64;
    localparam int EDGE_TH  = 32;
    localparam int LOSS_CNT = 3;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       bit_out;
    logic       bit_valid;
    logic       locked;
    logic [7:0] pp_last;

    int n_checks;
    int n_errors;
    int n_strobes;

    // Reference model state
    bit m_locked;
    int m_prev;
    bit m_prev_ok;
    int m_zeros;
    bit m_bit;
    bit m_valid;
    int m_pp;
    int win[$];

    ask_demod #(
        .BIT_LEN (BIT_LEN),
        .PP_TH   (PP_TH),
        .EDGE_TH (EDGE_TH),
        .LOSS_CNT(LOSS_CNT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .bit_out  (bit_out),
        .bit_valid(bit_valid),
        .locked   (locked),
        .pp_last  (pp_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked  = 1'b0;
        m_prev    = 0;
        m_prev_ok = 1'b0;
        m_zeros   = 0;
        m_bit     = 1'b0;
        m_valid   = 1'b0;
        m_pp      = 0;
        win.delete();
    endtask

    task automatic model_step(input int s);
        int d;
        int hi;
        int lo;
        m_valid = 1'b0;
        if (!m_locked) begin
            d = s - m_prev;
            if (d < 0) d = -d;
            if (m_prev_ok && d >= EDGE_TH) begin
                m_locked = 1'b1;
                m_zeros  = 0;
                win.delete();
                win.push_back(s);
            end
        end else begin
            win.push_back(s);
            if (win.size() == BIT_LEN) begin
                hi = 0;
                lo = 255;
                foreach (win[i]) begin
                    if (win[i] > hi) hi = win[i];
                    if (win[i] < lo) lo = win[i];
                end
                m_pp    = hi - lo;
                m_bit   = (m_pp >= PP_TH);
                m_valid = 1'b1;
                if (m_bit) begin
                    m_zeros = 0;
                end else begin
                    m_zeros++;
                    if (m_zeros == LOSS_CNT) m_locked = 1'b0;
                end
                win.delete();
            end
        end
        m_prev    = s;
        m_prev_ok = 1'b1;
    endtask

    // Drive one sample, let it be clocked in, then compare all outputs.
    task automatic step(input int s);
        din = 8'(s);
        @(posedge clk);
        model_step(s);
        #1;
        if (bit_valid) n_strobes++;
        check("bit_valid", int'(bit_valid), int'(m_valid));
        check("locked", int'(locked), int'(m_locked));
        check("bit_out", int'(bit_out), int'(m_bit));
        check("pp_last", int'(pp_last), m_pp);
        if (m_valid)
            $display("t=%0t strobe bit=%0d pp=%0d", $time, bit_out, pp_last);
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_bit_out", int'(bit_out), 0);
        check("rst_bit_valid", int'(bit_valid), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_pp_last", int'(pp_last), 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        $display("t=%0t reset applied and released", $time);
    endtask

    task automatic carrier_block(input int lo, input int hi, input int len);
        for (int i = 0; i < len; i++) step((i % 2 == 0) ? hi : lo);
    endtask

    task automatic const_block(input int lvl, input int len);
        for (int i = 0; i < len; i++) step(lvl);
    endtask

    initial begin
        int seg_kind;
        int lo;
        int hi;
        int len;
        n_checks  = 0;
        n_errors  = 0;
        n_strobes = 0;
        din       = 8'd0;
        rst_n     = 1'b1;
        model_reset();

        // Power-up reset
        #1 rst_n = 1'b0;
        #1;
        check("init_bit_out", int'(bit_out), 0);
        check("init_bit_valid", int'(bit_valid), 0);
        check("init_locked", int'(locked), 0);
        check("init_pp_last", int'(pp_last), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // No carrier: nothing decided
        const_block(0, 200);
        check("nocarrier_strobes", n_strobes, 0);
        async_reset();

        // Onset after 10 quiet samples, then bits 1,0,1,1,0 then two more
        // zero blocks which complete the loss of lock.
        const_block(0, 10);
        carrier_block(0, 255, BIT_LEN);
        const_block(0, BIT_LEN);
        carrier_block(0, 255, BIT_LEN);
        carrier_block(0, 255, BIT_LEN);
        const_block(0, BIT_LEN);
        const_block(0, BIT_LEN);
        const_block(0, BIT_LEN);
        check("pattern_strobes", n_strobes, 7);
        check("pattern_unlocked", int'(locked), 0);

        // Quiet after loss: no strobes
        const_block(0, 40);
        check("post_loss_strobes", n_strobes, 7);

        // Relock, then threshold boundary blocks pp=63 and pp=64
        carrier_block(0, 255, BIT_LEN);
        carrier_block(100, 163, BIT_LEN);
        check("pp63_bit", int'(bit_out), 0);
        carrier_block(100, 164, BIT_LEN);
        check("pp64_bit", int'(bit_out), 1);

        // Reset mid-window (cnt=7), then a 128 first sample is never edge-checked
        carrier_block(0, 255, 7);
        async_reset();
        const_block(128, 3);
        check("post_reset_unlocked", int'(locked), 0);
        const_block(0, 1);
        carrier_block(0, 128, 2 * BIT_LEN);

        // Randomized segments
        for (int seg = 0; seg < 150; seg++) begin
            seg_kind = $urandom_range(0, 29);
            len      = $urandom_range(1, 40);
            if (seg_kind == 0) begin
                async_reset();
            end else if (seg_kind < 15) begin
                lo = $urandom_range(0, 200);
                hi = lo + $urandom_range(0, 255 - lo);
                carrier_block(lo, hi, len);
            end else if (seg_kind < 20) begin
                lo = $urandom_range(60, 120);
                hi = lo + $urandom_range(60, 68);
                carrier_block(lo, hi, len);
            end else begin
                const_block($urandom_range(0, 255), len);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
